// File: rtl/acq_scheduler_if.sv
// Demod-side bundle of the acquisition scheduler.
//   epoch    : one-cycle code-epoch marker from the emulator
//   fa_sin   : correlator sine sum (demod fa_out_sin)
//   fa_cos   : correlator cosine sum (demod fa_out_cos)
//   fa_ready : correlator result-ready level
//   sync     : one-cycle cagen/NCO/demod restart pulse
//   t0, t1   : C/A G2 tap selects to cagen
// master = scheduler side, slave = demod/emulator side.
interface acq_scheduler_if #(
   parameter int SUM_W = 14
);
   logic             epoch;
   logic [SUM_W-1:0] fa_sin;
   logic [SUM_W-1:0] fa_cos;
   logic             fa_ready;
   logic             sync;
   logic [3:0]       t0;
   logic [3:0]       t1;

   modport master (
      input  epoch, fa_sin, fa_cos, fa_ready,
      output sync, t0, t1
   );

   modport slave (
      output epoch, fa_sin, fa_cos, fa_ready,
      input  sync, t0, t1
   );
endinterface

// File: rtl/acq_scheduler.sv
// Acquisition sequencer: walks PRN x code-phase candidates, fires sync at a
// phase-dependent delay after each code epoch, scores the correlator I/Q sums
// and keeps the best candidate.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   start, abort           : search request / synchronous search abort
//   prn_first, prn_last    : PRN index range (PRN-1), latched on start
//   threshold              : detection threshold, latched on start
//   dmd                    : demod-side bundle (epoch, fa_*, sync, t0, t1)
//   busy, done, found      : search status
//   best_prn/phase/energy  : best candidate so far
//   timeout_err            : sticky, a dwell timed out waiting for fa_ready
module acq_scheduler #(
   parameter int SUM_W       = 14,
   parameter int HALF        = 5000,
   parameter int NUM_PHASES  = 1023,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [4:0]           prn_first,
   input  logic [4:0]           prn_last,
   input  logic [SUM_W:0]       threshold,
   acq_scheduler_if.master      dmd,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic [4:0]           best_prn,
   output logic [9:0]           best_phase,
   output logic [SUM_W:0]       best_energy,
   output logic                 timeout_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SUM_W:0] HalfW    = (SUM_W + 1)'(HALF);
   localparam logic [9:0]     LastPh   = 10'(NUM_PHASES - 1);
   localparam logic [TW-1:0]  TimerEnd = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle, StArm, StDelay, StSync, StDwell, StEval, StNext, StDone
   } state_t;

   state_t           state_q;
   logic [4:0]       prn_q, prn_last_q, best_prn_q;
   logic [9:0]       phase_q, cnt_q, best_phase_q;
   logic [SUM_W:0]   thr_q, best_energy_q;
   logic [TW-1:0]    timer_q;
   logic [SUM_W-1:0] cap_sin_q, cap_cos_q;
   logic [3:0]       t0_q, t1_q;
   logic             rdy_prev_q, sync_q, busy_q, done_q, found_q, terr_q;

   // GPS G2 tap pairs, indexed by PRN-1, packed as {t0, t1}.
   function automatic logic [7:0] tap_rom(input logic [4:0] idx);
      logic [7:0] t;
      case (idx)
         5'd0:  t = {4'd2, 4'd6};   5'd1:  t = {4'd3, 4'd7};
         5'd2:  t = {4'd4, 4'd8};   5'd3:  t = {4'd5, 4'd9};
         5'd4:  t = {4'd1, 4'd9};   5'd5:  t = {4'd2, 4'd10};
         5'd6:  t = {4'd1, 4'd8};   5'd7:  t = {4'd2, 4'd9};
         5'd8:  t = {4'd3, 4'd10};  5'd9:  t = {4'd2, 4'd3};
         5'd10: t = {4'd3, 4'd4};   5'd11: t = {4'd5, 4'd6};
         5'd12: t = {4'd6, 4'd7};   5'd13: t = {4'd7, 4'd8};
         5'd14: t = {4'd8, 4'd9};   5'd15: t = {4'd9, 4'd10};
         5'd16: t = {4'd1, 4'd4};   5'd17: t = {4'd2, 4'd5};
         5'd18: t = {4'd3, 4'd6};   5'd19: t = {4'd4, 4'd7};
         5'd20: t = {4'd5, 4'd8};   5'd21: t = {4'd6, 4'd9};
         5'd22: t = {4'd1, 4'd3};   5'd23: t = {4'd4, 4'd6};
         5'd24: t = {4'd5, 4'd7};   5'd25: t = {4'd6, 4'd8};
         5'd26: t = {4'd7, 4'd9};   5'd27: t = {4'd8, 4'd10};
         5'd28: t = {4'd1, 4'd6};   5'd29: t = {4'd2, 4'd7};
         5'd30: t = {4'd3, 4'd8};   default: t = {4'd4, 4'd9};
      endcase
      return t;
   endfunction

   // Score = |sin - HALF| + |cos - HALF|; fits SUM_W+1 bits without saturation.
   logic [SUM_W:0] sin_x, cos_x, d_sin, d_cos, score;
   always_comb begin
      sin_x = {1'b0, cap_sin_q};
      cos_x = {1'b0, cap_cos_q};
      d_sin = (sin_x >= HalfW) ? (sin_x - HalfW) : (HalfW - sin_x);
      d_cos = (cos_x >= HalfW) ? (cos_x - HalfW) : (HalfW - cos_x);
      score = d_sin + d_cos;
   end

   // rdy_prev_q samples every cycle, so in DWELL only a fresh 0->1 counts.
   logic rdy_edge;
   assign rdy_edge = dmd.fa_ready && !rdy_prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         prn_q         <= '0;
         prn_last_q    <= '0;
         phase_q       <= '0;
         cnt_q         <= '0;
         thr_q         <= '0;
         timer_q       <= '0;
         cap_sin_q     <= '0;
         cap_cos_q     <= '0;
         t0_q          <= '0;
         t1_q          <= '0;
         rdy_prev_q    <= 1'b0;
         sync_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         terr_q        <= 1'b0;
         best_prn_q    <= '0;
         best_phase_q  <= '0;
         best_energy_q <= '0;
      end else begin
         sync_q     <= 1'b0;
         done_q     <= 1'b0;
         rdy_prev_q <= dmd.fa_ready;
         if (abort) begin
            // Also covers start+abort in IDLE: nothing is accepted.
            state_q <= StIdle;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     prn_last_q    <= prn_last;
                     thr_q         <= threshold;
                     prn_q         <= prn_first;
                     phase_q       <= '0;
                     {t0_q, t1_q}  <= tap_rom(prn_first);
                     best_prn_q    <= '0;
                     best_phase_q  <= '0;
                     best_energy_q <= '0;
                     terr_q        <= 1'b0;
                     found_q       <= 1'b0;
                     busy_q        <= 1'b1;
                     state_q       <= StArm;
                  end
               end
               StArm: begin
                  if (dmd.epoch) begin
                     cnt_q   <= phase_q;
                     state_q <= StDelay;
                  end
               end
               StDelay: begin
                  if (cnt_q == '0) begin
                     sync_q  <= 1'b1;
                     state_q <= StSync;
                  end else begin
                     cnt_q <= cnt_q - 10'd1;
                  end
               end
               StSync: begin
                  timer_q <= '0;
                  state_q <= StDwell;
               end
               StDwell: begin
                  if (rdy_edge) begin
                     cap_sin_q <= dmd.fa_sin;
                     cap_cos_q <= dmd.fa_cos;
                     state_q   <= StEval;
                  end else if (timer_q == TimerEnd) begin
                     // Score 0 can never beat the best, so skip EVAL.
                     terr_q  <= 1'b1;
                     state_q <= StNext;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               StEval: begin
                  if (score > best_energy_q) begin
                     best_energy_q <= score;
                     best_prn_q    <= prn_q;
                     best_phase_q  <= phase_q;
                  end
                  state_q <= StNext;
               end
               StNext: begin
                  if (phase_q < LastPh) begin
                     phase_q <= phase_q + 10'd1;
                     state_q <= StArm;
                  end else begin
                     phase_q <= '0;
                     if (prn_q < prn_last_q) begin
                        prn_q        <= prn_q + 5'd1;
                        {t0_q, t1_q} <= tap_rom(prn_q + 5'd1);
                        state_q      <= StArm;
                     end else begin
                        done_q  <= 1'b1;
                        found_q <= (best_energy_q >= thr_q);
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                     end
                  end
               end
               StDone:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // An abort arriving in the SYNC cycle itself suppresses the pulse.
   assign dmd.sync    = sync_q && !abort;
   assign dmd.t0      = t0_q;
   assign dmd.t1      = t1_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign best_prn    = best_prn_q;
   assign best_phase  = best_phase_q;
   assign best_energy = best_energy_q;
   assign timeout_err = terr_q;

endmodule
